// File: rtl/db15_serial_joy.sv
// db15_serial_joy: serial reader for a two-player DB15 joystick adapter (two chained PISO shift registers).
// Optional DB15_DEBOUNCE_EN publishes a frame only when it matches the previous frame.
module db15_serial_joy #(
  parameter int CLK_DIV   = 250,
  parameter int GAP_TICKS = 200
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_stb,
  output logic        valid
);
  localparam int TW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_TICKS + 1);
  typedef enum logic [2:0] {LOAD, SETTLE, CLK_LO, CLK_HI, PUBLISH, GAP} state_t;
  state_t state;
  logic [TW-1:0] div;
  logic [GW-1:0] gap;
  logic [4:0] k;
  logic [23:0] sr;
  logic [1:0] sync;
  logic tick;
  assign tick = div == TW'(CLK_DIV - 1);
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) div <= '0;
    else div <= tick ? '0 : div + 1'b1;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) sync <= '0;
    else sync <= {sync[0], JOY_DATA};
`ifdef DB15_DEBOUNCE_EN
  logic [23:0] prev;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) prev <= '0;
    else if (state == PUBLISH) prev <= sr;
`endif
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= LOAD;
      gap <= '0;
      k <= '0;
      sr <= '0;
      JOY_CLK <= 1'b1;
      JOY_LOAD <= 1'b1;
      joystick1 <= '0;
      joystick2 <= '0;
      frame_stb <= 1'b0;
      valid <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      case (state)
        LOAD: begin
          JOY_LOAD <= tick;
          if (tick) state <= SETTLE;
        end
        SETTLE: if (tick) begin
          state <= CLK_LO;
          k <= '0;
          JOY_CLK <= 1'b0;
        end
        CLK_LO: if (tick) begin
          sr[k] <= ~sync[1];
          state <= CLK_HI;
          JOY_CLK <= 1'b1;
        end
        CLK_HI: if (tick) begin
          if (k == 5'd23) state <= PUBLISH;
          else begin
            k <= k + 5'd1;
            state <= CLK_LO;
            JOY_CLK <= 1'b0;
          end
        end
        PUBLISH: begin
`ifdef DB15_DEBOUNCE_EN
          if (sr == prev) begin
`else
          begin
`endif
            joystick1 <= {4'h0, sr[11:0]};
            joystick2 <= {4'h0, sr[23:12]};
            frame_stb <= 1'b1;
            valid <= 1'b1;
          end
          gap <= '0;
          state <= GAP;
        end
        GAP: if (tick) begin
          if (gap == GW'(GAP_TICKS - 1)) begin
            state <= LOAD;
            JOY_LOAD <= 1'b0;
          end else gap <= gap + 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
endmodule

// File: tb/tb_db15_serial_joy.sv
// tb_db15_serial_joy: default-timing reset/first-frame checks on one instance, scoreboarded adapter frames on a fast instance.
module tb_db15_serial_joy;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n = 1'b0, d0 = 1'b1, jc0, jl0, stb0, v0;
  logic [15:0] a1, a2;
  db15_serial_joy u0 (.CLK(clk), .RESET_N(rst0_n), .JOY_DATA(d0), .JOY_CLK(jc0), .JOY_LOAD(jl0),
                      .joystick1(a1), .joystick2(a2), .frame_stb(stb0), .valid(v0));

  logic rst1_n = 1'b0, jd1, jc1, jl1, stb1, v1;
  logic [15:0] b1, b2;
  db15_serial_joy #(.CLK_DIV(4), .GAP_TICKS(1)) u1 (.CLK(clk), .RESET_N(rst1_n), .JOY_DATA(jd1), .JOY_CLK(jc1),
                      .JOY_LOAD(jl1), .joystick1(b1), .joystick2(b2), .frame_stb(stb1), .valid(v1));

  int checks = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Raw adapter frames, active-low, bit k is shifted out k-th.
  logic [23:0] frames [12] = '{24'hFFFFFF, 24'hFFDFFE, 24'hFFDFFE, 24'h000000, 24'h000000, 24'hFFFFFE,
                               24'hFFFFFF, 24'hFFFFFF, 24'hFFF0F0, 24'hFFFFFF, 24'h5A5A5A, 24'h5A5A5A};
  typedef struct packed {logic [15:0] j1; logic [15:0] j2;} exp_t;
  exp_t q[$];
  exp_t e;
  int fi = 0, idx = 0, nstb = 0;
  logic [23:0] cur = '1, prev_m = '0, s;
  logic [1:0] dly = '1;
  bit pushed = 0;
  logic [15:0] l1 = '0, l2 = '0;

  always @(negedge jl1) begin
    idx = 0;
    pushed = 0;
    if (fi < 12) begin
      cur = frames[fi];
      fi++;
      s = ~cur;
`ifdef DB15_DEBOUNCE_EN
      if (s == prev_m) begin
        q.push_back({4'h0, s[11:0], 4'h0, s[23:12]});
        pushed = 1;
      end
      prev_m = s;
`else
      q.push_back({4'h0, s[11:0], 4'h0, s[23:12]});
      pushed = 1;
`endif
    end else cur = '1;
  end
  always @(posedge jc1) idx++;
  always @(posedge clk) dly <= {dly[0], (idx < 24) ? cur[idx] : 1'b1};
  assign jd1 = dly[1];

  always @(negedge clk) begin
    if (!rst1_n) begin
      l1 = '0;
      l2 = '0;
    end else if (stb1) begin
      nstb++;
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected frame_stb: got %0h/%0h expected none", b1, b2);
      end else begin
        e = q.pop_front();
        chk("joystick1", {16'h0, b1}, {16'h0, e.j1});
        chk("joystick2", {16'h0, b2}, {16'h0, e.j2});
        chk("valid", {31'h0, v1}, 1);
      end
      l1 = b1;
      l2 = b2;
    end else chk("hold between frames", {b1, b2}, {l1, l2});
  end

  int n, fall, rise, w, exp_stb;
  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset JOY_CLK", {31'h0, jc0}, 1);
    chk("reset JOY_LOAD", {31'h0, jl0}, 1);
    chk("reset words", {a1, a2}, 0);
    chk("reset frame_stb", {31'h0, stb0}, 0);
    chk("reset valid", {31'h0, v0}, 0);
    rst0_n = 1'b1;
    n = 0; fall = 0; rise = 0;
    while (n < 13000) begin
      @(posedge clk);
      n++;
      #1;
      if (!jl0 && fall == 0) fall = n;
      if (jl0 && fall != 0 && rise == 0) rise = n;
      if (n == 12500) chk("valid before first frame", {31'h0, v0}, 0);
      if (stb0) break;
    end
    chk("JOY_LOAD fall edge", fall, 1);
    chk("JOY_LOAD rise edge", rise, 250);
    chk("first frame_stb edge", n, 12501);
    chk("idle joystick1", {16'h0, a1}, 0);
    chk("idle joystick2", {16'h0, a2}, 0);
    chk("valid after first frame", {31'h0, v0}, 1);
    @(posedge clk);
    #1;
    chk("frame_stb width", {31'h0, stb0}, 0);

    @(posedge clk);
    #2;
    rst1_n = 1'b1;
    w = 0;
    while (!(fi == 9 && idx == 10 && !jc1) && w < 20000) begin
      @(posedge clk);
      #2;
      w++;
    end
    chk("reached bit 10 of frame 8", {31'h0, w < 20000}, 1);
    rst1_n = 1'b0;
    if (pushed) void'(q.pop_back());
    pushed = 0;
    prev_m = '0;
    #1;
    chk("mid-frame reset JOY_CLK", {31'h0, jc1}, 1);
    chk("mid-frame reset JOY_LOAD", {31'h0, jl1}, 1);
    chk("mid-frame reset words", {b1, b2}, 0);
    chk("mid-frame reset valid", {30'h0, v1, stb1}, 0);
    repeat (2) @(posedge clk);
    #2;
    rst1_n = 1'b1;
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (stb1) break;
    end
    chk("frame_stb after reset release", n, 201);
    w = 0;
    while ((q.size() != 0 || fi < 12) && w < 5000) begin
      @(posedge clk);
      w++;
    end
    repeat (10) @(posedge clk);
    chk("scoreboard drained", q.size(), 0);
`ifdef DB15_DEBOUNCE_EN
    exp_stb = 6;
`else
    exp_stb = 11;
`endif
    chk("frame_stb count", nstb, exp_stb);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
